reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of the shared register.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  4  per-requester write request, req[i] for requester i.
REQ-005 SHALL have port: wdata  input  4*WIDTH  write data, requester i on bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port: gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-007 SHALL have port: q  output  WIDTH  shared register contents.
REQ-008 SHALL have port: qbar  output  WIDTH  bitwise complement of q, at all times.
REQ-009 SHALL have port: wr_done  output  1  one-cycle pulse, the cycle after q is updated.
REQ-010 SHALL have port: busy  output  1  high whenever state is GRANT.

Function
REQ-011 SHALL implement two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-012 SHALL keep a 2-bit round-robin pointer ptr; the winner is the first i with req[i]=1, searched ptr, ptr+1, ... modulo 4.
REQ-013 IDLE with any req high at an edge SHALL go to GRANT with gnt=onehot(winner); gnt appears the cycle after req.
REQ-014 In GRANT, if req[granted] is still high at the edge: q <= wdata of the granted requester, ptr <= granted+1 mod 4, wr_done=1 next cycle.
REQ-015 In GRANT, if req[granted] is low at the edge (abort): q unchanged, ptr unchanged, no wr_done.
REQ-016 Leaving GRANT SHALL re-arbitrate at the same edge using the updated ptr: any req high -> GRANT (new winner, no idle bubble); else IDLE.
REQ-017 Each grant SHALL last exactly one cycle (except under REQ-023), giving one write per cycle of sustained contention.
REQ-018 A request raised while another is granted SHALL wait; requests SHALL not be queued once dropped.
REQ-019 With all four requesting continuously, the grant order SHALL be 0,1,2,3,0,... from reset.

Reset
REQ-020 rst_n low SHALL immediately, without clk, force: state IDLE, gnt=0, q=0, qbar=all ones, wr_done=0, busy=0, ptr=0, lock counter=0.
REQ-021 Reset asserted during GRANT SHALL cancel the write; q stays 0 after reset release until the next completed grant.
REQ-022 Arbitration SHALL start at the first rising edge with rst_n high.

Configuration
REQ-023 With macro ARB_LOCK_EN defined, SHALL add input lock (1 bit): at the end of a successful GRANT with lock=1 and req[granted]=1, the same requester keeps gnt, writes again, ptr not advanced.
REQ-024 With ARB_LOCK_EN, a 2-bit counter SHALL limit locking to 4 consecutive writes; the 4th write rotates ptr regardless of lock; counter clears on rotation, abort or IDLE.
REQ-025 Without ARB_LOCK_EN, port lock and the counter SHALL not exist and behaviour SHALL be exactly REQ-011..REQ-019.

Verification
REQ-026 Reset: rst_n=0 mid-cycle with req=4'b1111 -> q=8'h00, qbar=8'hFF, gnt=0 immediately, before any clk edge.
REQ-027 Single: req=4'b0100, wdata[2]=8'hA5 held 2 cycles -> gnt=4'b0100 cycle 1, q=8'hA5, qbar=8'h5A, wr_done=1 cycle 2, ptr=3.
REQ-028 Contention: req=4'b1111, wdata lanes 8'h11,8'h22,8'h33,8'h44 -> gnt 0001,0010,0100,1000,0001; q sequence 11,22,33,44; busy stays 1.
REQ-029 Abort: req=4'b0010 granted, req dropped in GRANT -> q unchanged, no wr_done, next req=4'b0011 grants requester 1 (ptr unchanged).
REQ-030 Back-to-back: req[0] then req[3] raised during grant of 0 -> gnt 0001 then 1000 on consecutive cycles, no IDLE cycle.
REQ-031 ARB_LOCK_EN: req=4'b0011, lock=1 -> requester 0 granted 4 consecutive cycles, then gnt=4'b0010.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: four requesters share one WIDTH-bit register through a
// round-robin arbiter. Each grant lasts one cycle and the register is written
// at the end of the grant if the granted request is still asserted.
// Optional feature macro ARB_LOCK_EN adds a 'lock' input that lets the
// granted requester hold the grant for up to four consecutive writes.
module reg_write_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
   input  logic               lock,
`endif
   output logic [3:0]         gnt,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   qbar,
   output logic               wr_done,
   output logic               busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         gnt_q, gnt_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic               wr_done_q, wr_done_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         g_idx;
   logic               hold;
`ifdef ARB_LOCK_EN
   logic [1:0]         lock_cnt_q, lock_cnt_d;
`endif

   // First asserted request searching from p upward, modulo 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = p;
      found = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = p + k[1:0];
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   // Encode the registered one-hot grant back to an index.
   always_comb begin
      g_idx = 2'd0;
      for (int unsigned k = 0; k < 4; k++) begin
         if (gnt_q[k]) g_idx = k[1:0];
      end
   end

   // Next-state, write and re-arbitration logic.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      q_d       = q_q;
      wr_done_d = 1'b0;
      ptr_d     = ptr_q;
      hold      = 1'b0;
`ifdef ARB_LOCK_EN
      lock_cnt_d = '0;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               gnt_d   = onehot(rr_pick(req, ptr_q));
            end else begin
               gnt_d = '0;
            end
         end
         GRANT: begin
            if (req[g_idx]) begin
               q_d       = wdata[g_idx*WIDTH +: WIDTH];
               wr_done_d = 1'b1;
`ifdef ARB_LOCK_EN
               // Locked writes keep the grant; the fourth write always rotates.
               if (lock && (lock_cnt_q != 2'd3)) begin
                  hold       = 1'b1;
                  lock_cnt_d = lock_cnt_q + 2'd1;
               end else begin
                  ptr_d = g_idx + 2'd1;
               end
`else
               ptr_d = g_idx + 2'd1;
`endif
            end
            // Re-arbitrate at the same edge with the updated pointer.
            if (hold) begin
               gnt_d = gnt_q;
            end else if (|req) begin
               gnt_d = onehot(rr_pick(req, ptr_d));
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         q_q       <= '0;
         wr_done_q <= 1'b0;
         ptr_q     <= 2'd0;
`ifdef ARB_LOCK_EN
         lock_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         q_q       <= q_d;
         wr_done_q <= wr_done_d;
         ptr_q     <= ptr_d;
`ifdef ARB_LOCK_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign q       = q_q;
   assign qbar    = ~q_q;
   assign wr_done = wr_done_q;
   assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter with hand-computed expectations.
// When built with ARB_LOCK_EN the lock scenario is included.
module tb_reg_write_arbiter;

   localparam int WIDTH = 8;

   logic               clk;
   logic               rst_n;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] wdata;
   logic [3:0]         gnt;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   qbar;
   logic               wr_done;
   logic               busy;
`ifdef ARB_LOCK_EN
   logic               lock;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   reg_write_arbiter #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .wdata   (wdata),
`ifdef ARB_LOCK_EN
      .lock    (lock),
`endif
      .gnt     (gnt),
      .q       (q),
      .qbar    (qbar),
      .wr_done (wr_done),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      req   = 4'b0000;
`ifdef ARB_LOCK_EN
      lock  = 1'b0;
`endif
      #2;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req   = 4'b0000;
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef ARB_LOCK_EN
      lock  = 1'b0;
`endif
      #1;
      total_cnt++; if (q !== 8'h00) $display("FAIL reset_q0: got %h exp %h", q, 8'h00); else pass_cnt++;
      total_cnt++; if (qbar !== 8'hFF) $display("FAIL reset_qbar0: got %h exp %h", qbar, 8'hFF); else pass_cnt++;
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt0: got %b exp %b", gnt, 4'b0000); else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = 4'b1111;
      tick();
      total_cnt++; if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b exp %b", gnt, 4'b0001); else pass_cnt++;
      // Mid-cycle asynchronous reset while in GRANT.
      #3;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (q !== 8'h00) $display("FAIL reset_async_q: got %h exp %h", q, 8'h00); else pass_cnt++;
      total_cnt++; if (qbar !== 8'hFF) $display("FAIL reset_async_qbar: got %h exp %h", qbar, 8'hFF); else pass_cnt++;
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_async_gnt: got %b exp %b", gnt, 4'b0000); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b exp %b", busy, 1'b0); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b0) $display("FAIL reset_async_wr_done: got %b exp %b", wr_done, 1'b0); else pass_cnt++;
      tick();
      rst_n = 1'b1;
      req   = 4'b0000;
      tick();
      total_cnt++; if (q !== 8'h00) $display("FAIL reset_write_cancelled: got %h exp %h", q, 8'h00); else pass_cnt++;
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_idle_gnt: got %b exp %b", gnt, 4'b0000); else pass_cnt++;
   endtask

   task automatic test_single;
      do_reset();
      wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
      req   = 4'b0100;
      tick();
      total_cnt++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b exp %b", gnt, 4'b0100); else pass_cnt++;
      total_cnt++; if (q !== 8'h00) $display("FAIL single_q_before: got %h exp %h", q, 8'h00); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b0) $display("FAIL single_wr_done_c1: got %b exp %b", wr_done, 1'b0); else pass_cnt++;
      tick();
      total_cnt++; if (q !== 8'hA5) $display("FAIL single_q: got %h exp %h", q, 8'hA5); else pass_cnt++;
      total_cnt++; if (qbar !== 8'h5A) $display("FAIL single_qbar: got %h exp %h", qbar, 8'h5A); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b1) $display("FAIL single_wr_done: got %b exp %b", wr_done, 1'b1); else pass_cnt++;
      req = 4'b0000;
      tick();
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL single_idle_gnt: got %b exp %b", gnt, 4'b0000); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b exp %b", busy, 1'b0); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b0) $display("FAIL single_abort_wr_done: got %b exp %b", wr_done, 1'b0); else pass_cnt++;
      // Pointer should now be 3: requester 3 wins a full contention.
      req = 4'b1111;
      tick();
      total_cnt++; if (gnt !== 4'b1000) $display("FAIL single_ptr3: got %b exp %b", gnt, 4'b1000); else pass_cnt++;
      req = 4'b0000;
      tick();
   endtask

   task automatic test_contention;
      logic [3:0] exp_g [5];
      logic [7:0] exp_q [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         total_cnt++; if (gnt !== exp_g[k]) $display("FAIL contention_gnt%0d: got %b exp %b", k, gnt, exp_g[k]); else pass_cnt++;
         total_cnt++; if (q !== exp_q[k]) $display("FAIL contention_q%0d: got %h exp %h", k, q, exp_q[k]); else pass_cnt++;
         total_cnt++; if (busy !== 1'b1) $display("FAIL contention_busy%0d: got %b exp %b", k, busy, 1'b1); else pass_cnt++;
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_abort;
      do_reset();
      wdata = {8'h00, 8'h00, 8'h77, 8'h5C};
      req   = 4'b0001;
      tick();
      tick();
      total_cnt++; if (q !== 8'h5C) $display("FAIL abort_setup_q: got %h exp %h", q, 8'h5C); else pass_cnt++;
      // Requester 0 drops (abort), requester 1 wins with ptr=1.
      req = 4'b0010;
      tick();
      total_cnt++; if (gnt !== 4'b0010) $display("FAIL abort_gnt1: got %b exp %b", gnt, 4'b0010); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b0) $display("FAIL abort_first_wr_done: got %b exp %b", wr_done, 1'b0); else pass_cnt++;
      req = 4'b0000;
      tick();
      total_cnt++; if (q !== 8'h5C) $display("FAIL abort_q_unchanged: got %h exp %h", q, 8'h5C); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b0) $display("FAIL abort_wr_done: got %b exp %b", wr_done, 1'b0); else pass_cnt++;
      total_cnt++; if (gnt !== 4'b0000) $display("FAIL abort_idle: got %b exp %b", gnt, 4'b0000); else pass_cnt++;
      req = 4'b0011;
      tick();
      total_cnt++; if (gnt !== 4'b0010) $display("FAIL abort_ptr_kept: got %b exp %b", gnt, 4'b0010); else pass_cnt++;
      req = 4'b0000;
      tick();
   endtask

   task automatic test_back_to_back;
      do_reset();
      wdata = {8'hC3, 8'h00, 8'h00, 8'h3C};
      req   = 4'b0001;
      tick();
      total_cnt++; if (gnt !== 4'b0001) $display("FAIL b2b_gnt0: got %b exp %b", gnt, 4'b0001); else pass_cnt++;
      req = 4'b1001;
      tick();
      total_cnt++; if (gnt !== 4'b1000) $display("FAIL b2b_gnt3: got %b exp %b", gnt, 4'b1000); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b exp %b", busy, 1'b1); else pass_cnt++;
      total_cnt++; if (q !== 8'h3C) $display("FAIL b2b_q0: got %h exp %h", q, 8'h3C); else pass_cnt++;
      req = 4'b1000;
      tick();
      total_cnt++; if (q !== 8'hC3) $display("FAIL b2b_q3: got %h exp %h", q, 8'hC3); else pass_cnt++;
      total_cnt++; if (wr_done !== 1'b1) $display("FAIL b2b_wr_done: got %b exp %b", wr_done, 1'b1); else pass_cnt++;
      req = 4'b0000;
      tick();
      total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b exp %b", busy, 1'b0); else pass_cnt++;
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock;
      do_reset();
      wdata = {8'h00, 8'h00, 8'h02, 8'h01};
      lock  = 1'b1;
      req   = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         tick();
         total_cnt++; if (gnt !== 4'b0001) $display("FAIL lock_gnt0_%0d: got %b exp %b", k, gnt, 4'b0001); else pass_cnt++;
      end
      tick();
      total_cnt++; if (gnt !== 4'b0010) $display("FAIL lock_rotate: got %b exp %b", gnt, 4'b0010); else pass_cnt++;
      total_cnt++; if (q !== 8'h01) $display("FAIL lock_q: got %h exp %h", q, 8'h01); else pass_cnt++;
      tick();
      total_cnt++; if (gnt !== 4'b0010) $display("FAIL lock_hold1: got %b exp %b", gnt, 4'b0010); else pass_cnt++;
      total_cnt++; if (q !== 8'h02) $display("FAIL lock_q1: got %h exp %h", q, 8'h02); else pass_cnt++;
      req  = 4'b0000;
      lock = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_abort();
      test_back_to_back();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
